// File: rtl/sprite_pixel_source.sv
// Sprite pixel fetcher: walks a rectangle through 1-cycle-latency sprite BRAM in raster order
// and streams the pixels, each with a colour-key draw flag, through a 2-entry skid FIFO.
module sprite_pixel_source #(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [10:0]       cmd_x,
  input  logic [10:0]       cmd_y,
  input  logic [10:0]       cmd_width,
  input  logic [10:0]       cmd_height,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic              cmd_key_en,
  input  logic [7:0]        cmd_key,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [10:0]       pixel_x,
  output logic [10:0]       pixel_y,
  output logic [10:0]       width,
  output logic [10:0]       height,
  output logic [7:0]        pixel_data,
  output logic              pixel_valid,
  output logic              draw,
  input  logic              pixel_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_done;
  logic [10:0]       r_x;
  logic [10:0]       r_y;
  logic [10:0]       r_w;
  logic [10:0]       r_h;
  logic [10:0]       r_col;
  logic [10:0]       r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_key_en;
  logic [7:0]        r_key;

  logic              r_inflight;
  logic [7:0]        r_fifo_data [FIFO_DEPTH];
  logic              r_fifo_draw [FIFO_DEPTH];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_draw_in;

  // A slot freed by this cycle's handshake may be refilled by this cycle's read.
  assign w_pop      = (r_count != 2'd0) && pixel_ready;
  assign w_push     = r_inflight;
  assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == S_FETCH) && (w_occ < 3'(FIFO_DEPTH));
  assign w_last_col = (r_col == r_w - 11'd1);
  assign w_last_row = (r_row == r_h - 11'd1);
  assign w_draw_in  = !(r_key_en && (rom_data == r_key));

  assign rom_en      = w_issue;
  assign rom_addr    = r_addr;
  assign pixel_valid = (r_count != 2'd0);
  assign pixel_data  = r_fifo_data[r_rd_ptr];
  assign draw        = r_fifo_draw[r_rd_ptr];
  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign width       = r_w;
  assign height      = r_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_key_en    <= 1'b0;
      r_key       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_x         <= cmd_x;
            r_y         <= cmd_y;
            r_w         <= cmd_width;
            r_h         <= cmd_height;
            r_key_en    <= cmd_key_en;
            r_key       <= cmd_key;
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= cmd_base;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if ((cmd_width == 11'd0) || (cmd_height == 11'd0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_addr <= r_addr + 1'b1;
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 11'd1;
              if (w_last_row) r_state <= S_DRAIN;
            end else begin
              r_col <= r_col + 11'd1;
            end
          end
        end
        S_DRAIN: begin
          if ((r_count == 2'd0) && !r_inflight) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Skid FIFO: BRAM data lands one cycle after its read and is pushed at the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_draw[i] <= 1'b0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= rom_data;
        r_fifo_draw[r_wr_ptr] <= w_draw_in;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_sprite_pixel_source.sv
// Directed bench for sprite_pixel_source: one task per scenario, each with inline checks
// against hand-computed pixel streams, timings and geometry.
module tb_sprite_pixel_source;
  localparam int ADDR_W = 14;
  localparam int LIMIT  = 3000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [10:0]       cmd_x = '0, cmd_y = '0, cmd_width = '0, cmd_height = '0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic              cmd_key_en = 1'b0;
  logic [7:0]        cmd_key = '0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = '0;
  logic [10:0]       pixel_x, pixel_y, width, height;
  logic [7:0]        pixel_data;
  logic              pixel_valid, draw;
  logic              pixel_ready = 1'b0;
  logic              busy, done;

  sprite_pixel_source #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_width(cmd_width), .cmd_height(cmd_height),
    .cmd_base(cmd_base), .cmd_key_en(cmd_key_en), .cmd_key(cmd_key),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .width(width), .height(height),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .draw(draw),
    .pixel_ready(pixel_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int n_vec = 0;
  int n_fail = 0;

  logic [7:0]        q_data[$];
  logic              q_draw[$];
  logic [ADDR_W-1:0] q_addr[$];
  int   first_valid_s, last_hs_s, last_issue_s, done_s, done_cnt, hold_err, geom_err, max_out, hs;
  logic ready_after, timed_out;
  logic [15:0] rdy_pat = 16'b1011_0010_0110_1001;

  task automatic init_rom();
    for (int a = 0; a < (1 << ADDR_W); a++) rom[a] = 8'(a);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; pixel_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issues one command and records what the DUT does until the sample after done,
  // or until abort_hs handshakes have been observed.
  task automatic run_cmd(input logic [10:0] x, input logic [10:0] y, input logic [10:0] w,
                         input logic [10:0] h, input logic [ADDR_W-1:0] base, input logic ken,
                         input logic [7:0] key, input int mode, input int abort_hs);
    int s, waitc;
    logic pv_prev, pr_prev, dr_prev;
    logic [7:0] pd_prev;
    q_data.delete(); q_draw.delete(); q_addr.delete();
    first_valid_s = -1; last_hs_s = -1; last_issue_s = -1; done_s = -1; done_cnt = 0;
    hold_err = 0; geom_err = 0; max_out = 0; hs = 0; ready_after = 1'b0; timed_out = 1'b0;
    pixel_ready = 1'b0;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 100) begin
      @(posedge clk); #1; waitc++;
    end
    if (cmd_ready !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    cmd_x = x; cmd_y = y; cmd_width = w; cmd_height = h;
    cmd_base = base; cmd_key_en = ken; cmd_key = key; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_x = ~x; cmd_y = ~y; cmd_width = ~w; cmd_height = ~h;
    cmd_base = ~base; cmd_key_en = ~ken; cmd_key = ~key;
    pv_prev = 1'b0; pr_prev = 1'b0; pd_prev = '0; dr_prev = 1'b0;
    s = 0;
    while (s < LIMIT) begin
      if (s > 0) begin @(posedge clk); #1; end
      pixel_ready = (mode == 0) ? 1'b1 : rdy_pat[s % 16];
      #1;
      if (pixel_x !== x || pixel_y !== y || width !== w || height !== h) geom_err++;
      if (pv_prev && !pr_prev &&
          (pixel_valid !== 1'b1 || pixel_data !== pd_prev || draw !== dr_prev)) hold_err++;
      if (q_addr.size() - hs > max_out) max_out = q_addr.size() - hs;
      if (rom_en === 1'b1) begin q_addr.push_back(rom_addr); last_issue_s = s; end
      if (pixel_valid === 1'b1 && first_valid_s < 0) first_valid_s = s;
      if (done === 1'b1) begin done_cnt++; if (done_s < 0) done_s = s; end
      if (pixel_valid === 1'b1 && pixel_ready) begin
        q_data.push_back(pixel_data); q_draw.push_back(draw); hs++; last_hs_s = s;
      end
      pv_prev = pixel_valid; pr_prev = pixel_ready; pd_prev = pixel_data; dr_prev = draw;
      if (abort_hs > 0 && hs == abort_hs) break;
      if (done_s >= 0 && s == done_s + 1) begin ready_after = cmd_ready; break; end
      s++;
    end
    if (s >= LIMIT) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en: got %b want 0", rom_en); end
    n_vec++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_vec++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_valid: got %b want 0", pixel_valid); end
    n_vec++; if (pixel_data !== 8'h00) begin n_fail++; $display("FAIL reset_pixel_data: got %h want 00", pixel_data); end
    n_vec++; if (draw !== 1'b0) begin n_fail++; $display("FAIL reset_draw: got %b want 0", draw); end
    n_vec++; if ({pixel_x, pixel_y, width, height} !== 44'd0) begin
      n_fail++; $display("FAIL reset_geometry: got %h want 0", {pixel_x, pixel_y, width, height}); end
  endtask

  task automatic test_basic();
    init_rom();
    run_cmd(11'd10, 11'd20, 11'd4, 11'd2, 14'h100, 1'b0, 8'h00, 0, 0);
    n_vec++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
    n_vec++; if (q_addr.size() != 8) begin n_fail++; $display("FAIL basic_reads: got %0d want 8", q_addr.size()); end
    for (int i = 0; i < q_addr.size() && i < 8; i++) begin
      n_vec++; if (q_addr[i] !== 14'(14'h100 + i)) begin n_fail++; $display("FAIL basic_addr[%0d]: got %h want %h", i, q_addr[i], 14'(14'h100 + i)); end
    end
    n_vec++; if (last_issue_s != 7) begin n_fail++; $display("FAIL basic_issue_span: got %0d want 7", last_issue_s); end
    n_vec++; if (hs != 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", hs); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      n_vec++; if (q_data[i] !== 8'(i) || q_draw[i] !== 1'b1) begin n_fail++; $display("FAIL basic_pix[%0d]: got %h/%b want %h/1", i, q_data[i], q_draw[i], 8'(i)); end
    end
    n_vec++; if (first_valid_s != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", first_valid_s); end
    n_vec++; if (last_hs_s != 9) begin n_fail++; $display("FAIL basic_no_bubble: got %0d want 9", last_hs_s); end
    n_vec++; if (done_cnt != 1 || done_s != 11) begin n_fail++; $display("FAIL basic_done: got cnt %0d at %0d want 1 at 11", done_cnt, done_s); end
    n_vec++; if (ready_after !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b want 1", ready_after); end
    n_vec++; if (geom_err != 0) begin n_fail++; $display("FAIL basic_geometry: got %0d errors want 0", geom_err); end
  endtask

  task automatic test_backpressure();
    run_cmd(11'd3, 11'd4, 11'd4, 11'd2, 14'h100, 1'b0, 8'h00, 1, 0);
    n_vec++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
    n_vec++; if (hs != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", hs); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      n_vec++; if (q_data[i] !== 8'(i) || q_draw[i] !== 1'b1) begin n_fail++; $display("FAIL bp_pix[%0d]: got %h/%b want %h/1", i, q_data[i], q_draw[i], 8'(i)); end
    end
    n_vec++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold: got %0d errors want 0", hold_err); end
    n_vec++; if (max_out > 2) begin n_fail++; $display("FAIL bp_occupancy: got %0d want <=2", max_out); end
    n_vec++; if (q_addr.size() != 8) begin n_fail++; $display("FAIL bp_reads: got %0d want 8", q_addr.size()); end
    n_vec++; if (done_cnt != 1 || done_s != last_hs_s + 2) begin n_fail++; $display("FAIL bp_done: got cnt %0d at %0d want 1 at %0d", done_cnt, done_s, last_hs_s + 2); end
  endtask

  task automatic test_colour_key();
    logic [7:0] exp_d [3];
    logic       exp_k [3];
    exp_d = '{8'h05, 8'hFF, 8'h07};
    exp_k = '{1'b1, 1'b0, 1'b1};
    rom[14'h200] = 8'h05; rom[14'h201] = 8'hFF; rom[14'h202] = 8'h07;
    run_cmd(11'd0, 11'd0, 11'd3, 11'd1, 14'h200, 1'b1, 8'hFF, 0, 0);
    n_vec++; if (hs != 3) begin n_fail++; $display("FAIL key_count: got %0d want 3", hs); end
    for (int i = 0; i < q_data.size() && i < 3; i++) begin
      n_vec++; if (q_data[i] !== exp_d[i] || q_draw[i] !== exp_k[i]) begin n_fail++; $display("FAIL key_pix[%0d]: got %h/%b want %h/%b", i, q_data[i], q_draw[i], exp_d[i], exp_k[i]); end
    end
    n_vec++; if (done_cnt != 1) begin n_fail++; $display("FAIL key_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_degenerate();
    init_rom();
    run_cmd(11'd7, 11'd8, 11'd0, 11'd5, 14'h010, 1'b0, 8'h00, 0, 0);
    n_vec++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", q_addr.size()); end
    n_vec++; if (first_valid_s != -1) begin n_fail++; $display("FAIL zero_pixels: got valid at %0d want none", first_valid_s); end
    n_vec++; if (done_s != 0 || done_cnt != 1) begin n_fail++; $display("FAIL zero_done: got cnt %0d at %0d want 1 at 0", done_cnt, done_s); end
    n_vec++; if (ready_after !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after: got %b want 1", ready_after); end
    n_vec++; if (geom_err != 0) begin n_fail++; $display("FAIL zero_geometry: got %0d errors want 0", geom_err); end
    run_cmd(11'd1, 11'd1, 11'd1, 11'd1, 14'h055, 1'b1, 8'h55, 0, 0);
    n_vec++; if (hs != 1) begin n_fail++; $display("FAIL one_count: got %0d want 1", hs); end
    n_vec++; if (hs == 1 && (q_data[0] !== 8'h55 || q_draw[0] !== 1'b0)) begin n_fail++; $display("FAIL one_pix: got %h/%b want 55/0", q_data[0], q_draw[0]); end
    n_vec++; if (done_cnt != 1 || done_s != last_hs_s + 2) begin n_fail++; $display("FAIL one_done: got cnt %0d at %0d want 1 at %0d", done_cnt, done_s, last_hs_s + 2); end
  endtask

  task automatic test_addr_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    run_cmd(11'd0, 11'd0, 11'd4, 11'd1, 14'h3FFE, 1'b0, 8'h00, 0, 0);
    n_vec++; if (q_addr.size() != 4 || hs != 4) begin n_fail++; $display("FAIL wrap_count: got %0d reads %0d pixels want 4/4", q_addr.size(), hs); end
    for (int i = 0; i < q_addr.size() && i < 4; i++) begin
      n_vec++; if (q_addr[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, q_addr[i], exp_a[i]); end
    end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      n_vec++; if (q_data[i] !== exp_a[i][7:0]) begin n_fail++; $display("FAIL wrap_pix[%0d]: got %h want %h", i, q_data[i], exp_a[i][7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    run_cmd(11'd5, 11'd6, 11'd16, 11'd16, 14'h200, 1'b0, 8'h00, 0, 20);
    n_vec++; if (hs != 20 || timed_out !== 1'b0) begin n_fail++; $display("FAIL mid_progress: got %0d handshakes want 20", hs); end
    n_vec++; if (done_cnt != 0) begin n_fail++; $display("FAIL mid_early_done: got %0d want 0", done_cnt); end
    @(posedge clk); #1;
    reset = 1'b1; pixel_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_vec++; if (pixel_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state: got valid %b busy %b ready %b done %b want 0 0 1 0", pixel_valid, busy, cmd_ready, done); end
    saw_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1 || pixel_valid === 1'b1) saw_done = 1'b1; end
    n_vec++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_quiet: got activity %b want 0", saw_done); end
    run_cmd(11'd9, 11'd2, 11'd2, 11'd2, 14'h040, 1'b0, 8'h00, 0, 0);
    n_vec++; if (hs != 4) begin n_fail++; $display("FAIL mid_new_count: got %0d want 4", hs); end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      n_vec++; if (q_data[i] !== 8'(8'h40 + i) || q_draw[i] !== 1'b1) begin n_fail++; $display("FAIL mid_new_pix[%0d]: got %h/%b want %h/1", i, q_data[i], q_draw[i], 8'(8'h40 + i)); end
    end
    n_vec++; if (geom_err != 0 || done_cnt != 1) begin n_fail++; $display("FAIL mid_new_done: got geom %0d done %0d want 0/1", geom_err, done_cnt); end
  endtask

  initial begin
    init_rom();
    test_reset();
    test_basic();
    test_backpressure();
    test_colour_key();
    test_degenerate();
    test_addr_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
